gpio_pad_ctrl: RTL and testbench
================================

// Module: gpio_pad_ctrl
// PURPOSE
//   Parametrised GPIO pad controller between the SoC GPIO peripheral and board pads (Pano button, RGB LEDs, codec I2C).
//   Replaces per-bit top-level tristate assigns with one block.
//   Per channel: input synchroniser, optional debounce, edge-detect interrupt latch, registered output/enable, optional PWM.
// PARAMETERS
//   NUM_GPIO        32         number of channels
//   SYNC_STAGES     2          synchroniser flops per input (>=2)
//   DEBOUNCE_MASK   32'h2      bit i=1 -> channel i debounced (default: Pano button)
//   DEBOUNCE_CYCLES 500000     stable cycles required before a debounced input changes (10 ms @ 50 MHz)
//   PWM_BITS        8          PWM counter/duty width
// PORTS
//   clk_i          in   1               system clock (clk50 domain)
//   rst_i          in   1               synchronous reset, active-high
//   pad_in_i       in   NUM_GPIO        raw pad input (asynchronous)
//   pad_out_o      out  NUM_GPIO        pad output value
//   pad_oe_o       out  NUM_GPIO        pad output enable (1 = drive)
//   gpio_out_i     in   NUM_GPIO        SoC output value
//   gpio_oe_i      in   NUM_GPIO        SoC output enable
//   gpio_in_o      out  NUM_GPIO        conditioned input to SoC
//   irq_rise_en_i  in   NUM_GPIO        latch rising edges
//   irq_fall_en_i  in   NUM_GPIO        latch falling edges
//   irq_clr_i      in   NUM_GPIO        1-cycle write-1-to-clear pulse
//   irq_status_o   out  NUM_GPIO        latched edge status
//   irq_o          out  1               OR of irq_status_o, registered
//   pwm_en_i       in   NUM_GPIO        channel i output driven by PWM
//   pwm_duty_i     in   NUM_GPIO*PWM_BITS duty per channel, channel i at [i*PWM_BITS +: PWM_BITS]
// BEHAVIOUR
//   Reset: all outputs 0 (pads tristated); synchronisers, stable regs, counters, irq_status cleared.
//   Input path: pad -> SYNC_STAGES flops -> stable_q -> gpio_in_o; undebounced latency SYNC_STAGES+1 cycles.
//   Debounce (mask bit set): per-channel counter, ceil(log2(DEBOUNCE_CYCLES+1)) bits; counts while sync != stable_q.
//     - Clears to 0 on any cycle sync == stable_q.
//     - At count == DEBOUNCE_CYCLES-1 with mismatch still present, stable_q takes sync value; counter -> 0.
//     - Glitch shorter than DEBOUNCE_CYCLES: no change on gpio_in_o, no edge.
//     - Unmasked channels: no counter logic (stable_q = sync output, registered).
//   Edge detect: prev_q <= stable_q; rise = stable_q & ~prev_q; fall = ~stable_q & prev_q.
//     - Startup: arm_q goes 1 SYNC_STAGES+2 cycles after reset release; edges ignored until then.
//       Pads idle-high at reset raise no spurious rise.
//     - irq_status[i] <= (status | rise&rise_en | fall&fall_en) & ~clr, except set wins over same-cycle clr.
//     - irq_o = |irq_status_o, one cycle later.
//   Output path: pad_oe_o <= gpio_oe_i; pad_out_o <= gpio_out_i (or PWM); latency 1 cycle.
//     Output-only channels: caller ties gpio_oe_i high.
//   Reset asserted mid-debounce/mid-PWM: all state returns to reset values on next clk_i edge.
// CONFIGURATION
//   GPIO_PWM_EN defined:
//     - Free-running PWM_BITS counter, wraps 2^PWM_BITS-1 -> 0.
//     - Duty latched per channel when counter == 0 (glitch-free update).
//     - pwm_en_i[i]=1: pad_out_o[i] <= (cnt < duty_q[i]).
//       duty 0 = always low; duty 2^PWM_BITS-1 = low 1 cycle per period.
//   GPIO_PWM_EN undefined:
//     - No counter or duty registers.
//     - pwm_en_i and pwm_duty_i ignored; pad_out_o <= gpio_out_i.
// TESTING
//   1. Reset, pad_in_i=32'h2 held high, rise_en all 1 -> gpio_in_o[1]=1 after DEBOUNCE_CYCLES+3; irq_status_o stays 0.
//   2. Bit 1 (debounced), DEBOUNCE_CYCLES=16: 15-cycle low glitch -> no change.
//      Held low 16 cycles, fall_en[1]=1 -> gpio_in_o[1]=0 then irq_status_o[1]=1, irq_o=1 one cycle later.
//   3. Bit 3 rise_en=1, pulse pad high; assert irq_clr_i[3] in same cycle as a new rising edge -> status stays 1.
//      Lone clr -> status 0 next cycle.
//   4. gpio_oe_i=32'h18, gpio_out_i=32'h08 -> pad_oe_o=32'h18, pad_out_o=32'h08 one cycle later; gpio_oe_i=0 -> pads tristated.
//   5. GPIO_PWM_EN, PWM_BITS=8, pwm_en[2]=1, duty=64 -> exactly 64 high of every 256 cycles.
//      Duty change mid-period takes effect at next wrap; duty 0 never high.
//   6. Assert rst_i mid-debounce and mid-PWM -> all outputs 0 next edge, counters restart, no irq after release.

Source files
------------

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: per-channel input sync/debounce/edge-irq and registered pad outputs.
// Optional PWM output source is compiled in when GPIO_PWM_EN is defined.
module gpio_pad_ctrl #(
    parameter int unsigned          NUM_GPIO        = 32,
    parameter int unsigned          SYNC_STAGES     = 2,
    parameter logic [NUM_GPIO-1:0]  DEBOUNCE_MASK   = NUM_GPIO'(2),
    parameter int unsigned          DEBOUNCE_CYCLES = 500000,
    parameter int unsigned          PWM_BITS        = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_GPIO-1:0]          pad_in_i,
    output logic [NUM_GPIO-1:0]          pad_out_o,
    output logic [NUM_GPIO-1:0]          pad_oe_o,
    input  logic [NUM_GPIO-1:0]          gpio_out_i,
    input  logic [NUM_GPIO-1:0]          gpio_oe_i,
    output logic [NUM_GPIO-1:0]          gpio_in_o,
    input  logic [NUM_GPIO-1:0]          irq_rise_en_i,
    input  logic [NUM_GPIO-1:0]          irq_fall_en_i,
    input  logic [NUM_GPIO-1:0]          irq_clr_i,
    output logic [NUM_GPIO-1:0]          irq_status_o,
    output logic                         irq_o,
    input  logic [NUM_GPIO-1:0]          pwm_en_i,
    input  logic [NUM_GPIO*PWM_BITS-1:0] pwm_duty_i
);

    localparam int unsigned     DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned      ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] r_sync;
    logic [NUM_GPIO-1:0]                  w_sync;
    logic [NUM_GPIO-1:0]                  w_stable;
    logic [NUM_GPIO-1:0]                  r_prev;
    logic [NUM_GPIO-1:0]                  w_rise;
    logic [NUM_GPIO-1:0]                  w_fall;
    logic [NUM_GPIO-1:0]                  w_irq_set;
    logic [NUM_GPIO-1:0]                  r_irq_status;
    logic                                 r_irq;
    logic [NUM_GPIO-1:0]                  r_pad_out;
    logic [NUM_GPIO-1:0]                  r_pad_oe;
    logic [NUM_GPIO-1:0]                  w_out_next;
    logic [ARM_W-1:0]                     r_arm_cnt;
    logic                                 r_arm;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pad_in_i};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Arms edge detection once the synchroniser and stable/prev stages hold real pad data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_arm_cnt <= '0;
            r_arm     <= 1'b0;
        end else if (!r_arm) begin
            if (r_arm_cnt == ARM_LAST) begin
                r_arm <= 1'b1;
            end else begin
                r_arm_cnt <= r_arm_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_chan
        if (DEBOUNCE_MASK[g]) begin : g_db
            logic [DB_W-1:0] r_db_cnt;
            logic            r_stable;

            // Until armed, stable follows sync so the pad level at reset is captured without an edge.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_db_cnt <= '0;
                    r_stable <= 1'b0;
                end else if (!r_arm) begin
                    r_db_cnt <= '0;
                    r_stable <= w_sync[g];
                end else if (w_sync[g] == r_stable) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_LAST) begin
                    r_db_cnt <= '0;
                    r_stable <= w_sync[g];
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end

            assign w_stable[g] = r_stable;
        end else begin : g_nodb
            logic r_stable;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_stable <= 1'b0;
                end else begin
                    r_stable <= w_sync[g];
                end
            end

            assign w_stable[g] = r_stable;
        end
    end

    assign w_rise    = w_stable & ~r_prev;
    assign w_fall    = ~w_stable & r_prev;
    assign w_irq_set = r_arm ? ((w_rise & irq_rise_en_i) | (w_fall & irq_fall_en_i))
                             : '0;

    // A new edge in the same cycle as its clear keeps the status bit set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prev       <= '0;
            r_irq_status <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_prev       <= w_stable;
            r_irq_status <= (r_irq_status & ~irq_clr_i) | w_irq_set;
            r_irq        <= |r_irq_status;
        end
    end

`ifdef GPIO_PWM_EN
    logic [PWM_BITS-1:0]               r_pwm_cnt;
    logic [NUM_GPIO-1:0][PWM_BITS-1:0] r_duty;
    logic [NUM_GPIO-1:0][PWM_BITS-1:0] w_duty_cur;
    logic [NUM_GPIO-1:0]               w_pwm;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_duty    <= w_duty_cur;
        end
    end

    // The duty sampled at count 0 governs the whole period, including that first cycle.
    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_pwm
        assign w_duty_cur[g] = (r_pwm_cnt == '0) ? pwm_duty_i[g*PWM_BITS +: PWM_BITS]
                                                 : r_duty[g];
        assign w_pwm[g]      = (r_pwm_cnt < w_duty_cur[g]);
    end

    assign w_out_next = (pwm_en_i & w_pwm) | (~pwm_en_i & gpio_out_i);
`else
    logic w_unused_pwm;
    assign w_unused_pwm = ^{pwm_en_i, pwm_duty_i};
    assign w_out_next   = gpio_out_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pad_out <= '0;
            r_pad_oe  <= '0;
        end else begin
            r_pad_out <= w_out_next;
            r_pad_oe  <= gpio_oe_i;
        end
    end

    assign pad_out_o    = r_pad_out;
    assign pad_oe_o     = r_pad_oe;
    assign gpio_in_o    = w_stable;
    assign irq_status_o = r_irq_status;
    assign irq_o        = r_irq;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: directed scenarios plus randomized traffic
// against a cycle-level reference model built from pad history.
module tb_gpio_pad_ctrl;

    localparam int unsigned NUM_GPIO  = 32;
    localparam int unsigned SYNC      = 2;
    localparam int unsigned DB_CYCLES = 16;
    localparam int unsigned PWM_BITS  = 8;
    localparam int unsigned PERIOD    = 1 << PWM_BITS;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NUM_GPIO-1:0]          pad_in;
    logic [NUM_GPIO-1:0]          pad_out;
    logic [NUM_GPIO-1:0]          pad_oe;
    logic [NUM_GPIO-1:0]          gpio_out;
    logic [NUM_GPIO-1:0]          gpio_oe;
    logic [NUM_GPIO-1:0]          gpio_in;
    logic [NUM_GPIO-1:0]          rise_en;
    logic [NUM_GPIO-1:0]          fall_en;
    logic [NUM_GPIO-1:0]          clr;
    logic [NUM_GPIO-1:0]          irq_status;
    logic                         irq;
    logic [NUM_GPIO-1:0]          pwm_en;
    logic [NUM_GPIO*PWM_BITS-1:0] duty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpio_pad_ctrl #(
        .NUM_GPIO        (NUM_GPIO),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_MASK   (32'h2),
        .DEBOUNCE_CYCLES (DB_CYCLES),
        .PWM_BITS        (PWM_BITS)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pad_in_i      (pad_in),
        .pad_out_o     (pad_out),
        .pad_oe_o      (pad_oe),
        .gpio_out_i    (gpio_out),
        .gpio_oe_i     (gpio_oe),
        .gpio_in_o     (gpio_in),
        .irq_rise_en_i (rise_en),
        .irq_fall_en_i (fall_en),
        .irq_clr_i     (clr),
        .irq_status_o  (irq_status),
        .irq_o         (irq),
        .pwm_en_i      (pwm_en),
        .pwm_duty_i    (duty)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        gpio_out = '0;
        gpio_oe  = '0;
        rise_en  = '0;
        fall_en  = '0;
        clr      = '0;
        pwm_en   = '0;
        duty     = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst      = 1'b1;
        pad_in   = 32'h2;
        gpio_out = '1;
        gpio_oe  = '1;
        rise_en  = '1;
        repeat (3) tick();
        n_checks++;
        if (pad_out !== '0) begin
            n_fail++; $display("FAIL reset_pad_out got=%h exp=0", pad_out);
        end
        n_checks++;
        if (pad_oe !== '0) begin
            n_fail++; $display("FAIL reset_pad_oe got=%h exp=0", pad_oe);
        end
        n_checks++;
        if (gpio_in !== '0) begin
            n_fail++; $display("FAIL reset_gpio_in got=%h exp=0", gpio_in);
        end
        n_checks++;
        if (irq_status !== '0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq got=%h/%b exp=0/0", irq_status, irq);
        end
        rst = 1'b0;
        for (int j = 1; j <= int'(DB_CYCLES) + 3; j++) begin
            tick();
            n_checks++;
            if (irq_status !== '0 || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL startup_no_irq cyc=%0d got=%h/%b exp=0/0", j, irq_status, irq);
            end
        end
        n_checks++;
        if (gpio_in !== 32'h2) begin
            n_fail++; $display("FAIL startup_gpio_in got=%h exp=00000002", gpio_in);
        end
        n_checks++;
        if (pad_oe !== '1 || pad_out !== '1) begin
            n_fail++; $display("FAIL startup_out got=%h/%h exp=ffffffff", pad_oe, pad_out);
        end
    endtask

    task automatic test_debounce();
        logic e_in, e_st, e_irq;
        idle_inputs();
        fall_en[1] = 1'b1;
        pad_in[1]  = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            tick();
            if (j == int'(DB_CYCLES) - 1) pad_in[1] = 1'b1;
            n_checks++;
            if (gpio_in[1] !== 1'b1 || irq_status !== '0) begin
                n_fail++;
                $display("FAIL glitch cyc=%0d got in=%b st=%h exp in=1 st=0", j, gpio_in[1],
                         irq_status);
            end
        end
        pad_in[1] = 1'b0;
        for (int j = 1; j <= 22; j++) begin
            tick();
            e_in  = (j >= int'(SYNC + DB_CYCLES)) ? 1'b0 : 1'b1;
            e_st  = (j >= int'(SYNC + DB_CYCLES) + 1);
            e_irq = (j >= int'(SYNC + DB_CYCLES) + 2);
            n_checks++;
            if (gpio_in[1] !== e_in || irq_status[1] !== e_st || irq !== e_irq) begin
                n_fail++;
                $display("FAIL debounce_fall cyc=%0d got=%b%b%b exp=%b%b%b", j, gpio_in[1],
                         irq_status[1], irq, e_in, e_st, e_irq);
            end
        end
        clr[1] = 1'b1;
        tick();
        clr = '0;
        n_checks++;
        if (irq_status[1] !== 1'b0 || irq !== 1'b1) begin
            n_fail++; $display("FAIL debounce_clr got=%b/%b exp=0/1", irq_status[1], irq);
        end
        tick();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL debounce_irq_drop got=%b exp=0", irq);
        end
    endtask

    task automatic test_clr_collision();
        idle_inputs();
        rise_en[3] = 1'b1;
        pad_in[3]  = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (irq_status[3] !== 1'b1) begin
            n_fail++; $display("FAIL rise_latch got=%b exp=1", irq_status[3]);
        end
        tick();
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL rise_irq got=%b exp=1", irq);
        end
        pad_in[3] = 1'b0;
        clr[3]    = 1'b1;
        tick();
        clr = '0;
        n_checks++;
        if (irq_status[3] !== 1'b0) begin
            n_fail++; $display("FAIL clr_before_collision got=%b exp=0", irq_status[3]);
        end
        repeat (4) tick();
        pad_in[3] = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (irq_status[3] !== 1'b0) begin
            n_fail++; $display("FAIL pre_collision got=%b exp=0", irq_status[3]);
        end
        clr[3] = 1'b1;
        tick();
        clr = '0;
        n_checks++;
        if (irq_status[3] !== 1'b1) begin
            n_fail++; $display("FAIL set_wins_over_clr got=%b exp=1", irq_status[3]);
        end
        clr[3] = 1'b1;
        tick();
        clr = '0;
        n_checks++;
        if (irq_status[3] !== 1'b0) begin
            n_fail++; $display("FAIL lone_clr got=%b exp=0", irq_status[3]);
        end
    endtask

    task automatic test_output();
        idle_inputs();
        gpio_oe  = 32'h18;
        gpio_out = 32'h08;
        tick();
        n_checks++;
        if (pad_oe !== 32'h18 || pad_out !== 32'h08) begin
            n_fail++; $display("FAIL out_drive got=%h/%h exp=18/08", pad_oe, pad_out);
        end
        gpio_oe = '0;
        tick();
        n_checks++;
        if (pad_oe !== '0) begin
            n_fail++; $display("FAIL out_tristate got=%h exp=0", pad_oe);
        end
    endtask

    // Model: gpio_in after edge n equals the pad presented SYNC edges earlier; edges come
    // from consecutive stable values, status is sticky with clear and set-priority.
    task automatic test_random();
        logic [NUM_GPIO-1:0] q[$];
        logic [NUM_GPIO-1:0] p, e_st, e_in, st1, st2;
        logic                e_irq;
        idle_inputs();
        rst    = 1'b1;
        pad_in = $urandom() | 32'h2;
        repeat (2) tick();
        rst = 1'b0;
        repeat (SYNC + 4) tick();
        for (int k = 0; k < 4; k++) q.push_back(pad_in);
        e_st = '0;
        for (int c = 0; c < 300; c++) begin
            p        = $urandom();
            p[1]     = 1'b1;
            pad_in   = p;
            gpio_out = $urandom();
            gpio_oe  = $urandom();
            rise_en  = $urandom();
            fall_en  = $urandom();
            clr      = $urandom() & $urandom() & $urandom();
`ifndef GPIO_PWM_EN
            pwm_en   = $urandom();
            for (int k = 0; k < int'(PWM_BITS); k++) duty[k*32 +: 32] = $urandom();
`endif
            q.push_back(p);
            tick();
            e_in  = q[q.size()-1-SYNC];
            st1   = q[q.size()-2-SYNC];
            st2   = q[q.size()-3-SYNC];
            e_irq = |e_st;
            e_st  = (e_st & ~clr) | (rise_en & st1 & ~st2) | (fall_en & ~st1 & st2);
            n_checks++;
            if (gpio_in !== e_in) begin
                n_fail++; $display("FAIL rnd_gpio_in c=%0d got=%h exp=%h", c, gpio_in, e_in);
            end
            n_checks++;
            if (irq_status !== e_st) begin
                n_fail++; $display("FAIL rnd_status c=%0d got=%h exp=%h", c, irq_status, e_st);
            end
            n_checks++;
            if (irq !== e_irq) begin
                n_fail++; $display("FAIL rnd_irq c=%0d got=%b exp=%b", c, irq, e_irq);
            end
            n_checks++;
            if (pad_out !== gpio_out || pad_oe !== gpio_oe) begin
                n_fail++;
                $display("FAIL rnd_out c=%0d got=%h/%h exp=%h/%h", c, pad_out, pad_oe, gpio_out,
                         gpio_oe);
            end
        end
    endtask

`ifdef GPIO_PWM_EN
    // Model: period k covers edges k*PERIOD+1 .. (k+1)*PERIOD; output high for the first
    // duty cycles, where duty is the request seen at the first edge of the period.
    task automatic test_pwm();
        int unsigned req, act, highs, c;
        logic        e;
        idle_inputs();
        rst      = 1'b1;
        pwm_en   = 32'h4;
        gpio_out = 32'h1;
        req      = 64;
        act      = 0;
        highs    = 0;
        tick();
        rst = 1'b0;
        for (int n = 1; n <= int'(PERIOD) * 5; n++) begin
            if (n == int'(PERIOD) + 100)     req = 200;
            if (n == 3 * int'(PERIOD) + 37)  req = 0;
            if (n == 4 * int'(PERIOD) + 5)   req = 255;
            duty[2*PWM_BITS +: PWM_BITS] = req[PWM_BITS-1:0];
            duty[0 +: PWM_BITS]          = 8'($urandom());
            tick();
            c = (n - 1) % PERIOD;
            if (c == 0) begin
                if (n > 1) begin
                    n_checks++;
                    if (highs != act) begin
                        n_fail++; $display("FAIL pwm_period n=%0d got=%0d exp=%0d", n, highs, act);
                    end
                end
                act   = req;
                highs = 0;
            end
            e = (c < act);
            if (pad_out[2]) highs++;
            n_checks++;
            if (pad_out[2] !== e || pad_out[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL pwm_cycle n=%0d got=%b%b exp=%b1", n, pad_out[2], pad_out[0], e);
            end
        end
        n_checks++;
        if (highs != act) begin
            n_fail++; $display("FAIL pwm_last_period got=%0d exp=%0d", highs, act);
        end
    endtask
`else
    task automatic test_pwm();
        idle_inputs();
        for (int j = 0; j < 10; j++) begin
            pwm_en   = $urandom();
            gpio_out = $urandom();
            for (int k = 0; k < int'(PWM_BITS); k++) duty[k*32 +: 32] = $urandom();
            tick();
            n_checks++;
            if (pad_out !== gpio_out) begin
                n_fail++; $display("FAIL pwm_ignored got=%h exp=%h", pad_out, gpio_out);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        idle_inputs();
        pad_in  = 32'h2;
        gpio_oe = '1;
        pwm_en  = 32'h4;
        duty[2*PWM_BITS +: PWM_BITS] = 8'd64;
        repeat (40) tick();
        pad_in[1] = 1'b0;
        repeat (SYNC + 8) tick();
        rise_en = '1;
        fall_en = '1;
        rst     = 1'b1;
        tick();
        n_checks++;
        if (pad_out !== '0 || pad_oe !== '0 || gpio_in !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_out got=%h/%h/%h exp=0/0/0", pad_out, pad_oe, gpio_in);
        end
        n_checks++;
        if (irq_status !== '0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_irq got=%h/%b exp=0/0", irq_status, irq);
        end
        rst = 1'b0;
        for (int j = 1; j <= 80; j++) begin
            tick();
            n_checks++;
            if (irq_status !== '0 || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_irq cyc=%0d got=%h/%b exp=0/0", j, irq_status, irq);
            end
`ifdef GPIO_PWM_EN
            if (j == 1 || j == 70) begin
                n_checks++;
                if (pad_out[2] !== (j == 1)) begin
                    n_fail++;
                    $display("FAIL pwm_restart cyc=%0d got=%b exp=%b", j, pad_out[2], j == 1);
                end
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_clr_collision();
        test_output();
        test_random();
        test_pwm();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
